// File: rtl/div_unit_pkg.sv
// Shared constants and state encoding for the execute-stage divider.
package div_unit_pkg;

    localparam int N_REG = 32;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_STEP = 6'd31;

    // DIV_BYZERO is reserved; a zero divisor is handled by jumping straight to DIV_END.
    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage divide handshake: execute is the master, the divider the slave.
interface div_unit_if;

    logic                           divsigned;
    logic [div_unit_pkg::N_REG-1:0] dividend;
    logic [div_unit_pkg::N_REG-1:0] divisor;
    logic                           divstart;
    logic                           annul;
    logic [div_unit_pkg::N_REG-1:0] quotient;
    logic [div_unit_pkg::N_REG-1:0] remainder;
    logic                           div_done;
    logic                           div_ready;

    modport master (
        output divsigned, dividend, divisor, divstart, annul,
        input  quotient, remainder, div_done, div_ready
    );

    modport slave (
        input  divsigned, dividend, divisor, divstart, annul,
        output quotient, remainder, div_done, div_ready
    );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU: one quotient bit per cycle,
// quotient and remainder presented for a single cycle with the done strobe.
module div_unit
    import div_unit_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    div_unit_if.slave  bus
);

    div_state_e             state_q, state_d;
    logic [N_REG-1:0]       dvd_q;
    logic [N_REG-1:0]       dvs_q;
    logic [N_REG-1:0]       rem_q;
    logic [N_REG-1:0]       quo_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   quo_sign_q;
    logic                   rem_sign_q;
    logic [N_REG-1:0]       res_quo_q;
    logic [N_REG-1:0]       res_rem_q;

    logic [N_REG:0]         trial;
    logic [N_REG:0]         diff;
    logic                   fits;
    logic [N_REG-1:0]       rem_step;
    logic [N_REG-1:0]       quo_step;
    logic                   start_ok;

    function automatic logic [N_REG-1:0] negate_if(input logic [N_REG-1:0] v, input logic neg);
        return neg ? (~v + N_REG'(1)) : v;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= DIV_FREE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        trial    = {rem_q, dvd_q[N_REG-1]};
        diff     = trial - {1'b0, dvs_q};
        fits     = ~diff[N_REG];
        rem_step = fits ? diff[N_REG-1:0] : trial[N_REG-1:0];
        quo_step = {quo_q[N_REG-2:0], fits};
        start_ok = !bus.annul && (bus.divstart == DIV_START);
        case (state_q)
            DIV_FREE: begin
                if (start_ok) state_d = (bus.divisor == '0) ? DIV_END : DIV_ON;
            end
            DIV_ON: begin
                if (bus.annul)               state_d = DIV_FREE;
                else if (cnt_q == LAST_STEP) state_d = DIV_END;
            end
            DIV_END: state_d = DIV_FREE;
            default: state_d = DIV_FREE;
        endcase
    end

    // Result registers default to zero every cycle, so they are nonzero only in DIV_END.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            quo_sign_q <= 1'b0;
            rem_sign_q <= 1'b0;
            res_quo_q  <= '0;
            res_rem_q  <= '0;
        end else begin
            res_quo_q <= '0;
            res_rem_q <= '0;
            case (state_q)
                DIV_FREE: begin
                    if (start_ok && bus.divisor != '0) begin
                        dvd_q      <= negate_if(bus.dividend, bus.divsigned & bus.dividend[N_REG-1]);
                        dvs_q      <= negate_if(bus.divisor,  bus.divsigned & bus.divisor[N_REG-1]);
                        quo_sign_q <= bus.divsigned & (bus.dividend[N_REG-1] ^ bus.divisor[N_REG-1]);
                        rem_sign_q <= bus.divsigned & bus.dividend[N_REG-1];
                        rem_q      <= '0;
                        quo_q      <= '0;
                        cnt_q      <= '0;
                    end
                end
                DIV_ON: begin
                    if (!bus.annul) begin
                        dvd_q <= {dvd_q[N_REG-2:0], 1'b0};
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_STEP) begin
                            res_quo_q <= negate_if(quo_step, quo_sign_q);
                            res_rem_q <= negate_if(rem_step, rem_sign_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = res_quo_q;
    assign bus.remainder = res_rem_q;
    assign bus.div_ready = (state_q == DIV_FREE) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    assign bus.div_done  = (state_q == DIV_END)  ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomised checks of div_unit results, latency and abort behaviour.
module tb_div_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    div_unit_if bus();

    div_unit u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input int exp_lat,
                          input logic [31:0] eq, input logic [31:0] er);
        int lat;
        int busy_ready;
        chk({tag, "_idle_rdy"}, 32'(bus.div_ready), 32'd1);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.divsigned = sgn;
        bus.divstart  = 1'b1;
        tick();
        bus.divstart  = 1'b0;
        lat        = 0;
        busy_ready = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.div_done) break;
            if (bus.div_ready) busy_ready++;
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy_rdy"}, 32'(busy_ready), 32'd0);
        chk({tag, "_rdy_at_done"}, 32'(bus.div_ready), 32'd0);
        chk({tag, "_q"}, bus.quotient, eq);
        chk({tag, "_r"}, bus.remainder, er);
        tick();
        chk({tag, "_done_after"}, 32'(bus.div_done), 32'd0);
        chk({tag, "_rdy_after"}, 32'(bus.div_ready), 32'd1);
        chk({tag, "_q_after"}, bus.quotient, 32'd0);
    endtask

    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                sa = a;
                sb = b;
                q  = 32'(sa / sb);
                r  = 32'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rs;
        int          done_cnt;
        int          first_done;
        int          last_done;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.divsigned = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.divstart  = 1'b0;
        bus.annul     = 1'b0;

        tick();
        chk("rst_ready", 32'(bus.div_ready), 32'd1);
        chk("rst_done", 32'(bus.div_done), 32'd0);
        chk("rst_q", bus.quotient, 32'd0);
        chk("rst_r", bus.remainder, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        do_div("u100_7",  32'd100,        32'd7,          1'b0, 32, 32'd14,         32'd2);
        do_div("s-7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
        do_div("s7_-2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32, 32'hFFFF_FFFD,  32'd1);
        do_div("s-100_-7",32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32, 32'd14,         32'hFFFF_FFFE);
        do_div("s_ovf",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32, 32'h8000_0000,  32'd0);
        do_div("u_ovf",   32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32, 32'd0,          32'h8000_0000);
        do_div("u_max_1", 32'hFFFF_FFFF,  32'd1,          1'b0, 32, 32'hFFFF_FFFF,  32'd0);
        do_div("u_small", 32'd3,          32'd10,         1'b0, 32, 32'd0,          32'd3);
        do_div("zero_div",32'd5,          32'd0,          1'b0, 0,  32'd0,          32'd0);

        // annul at step 10
        bus.dividend = 32'd100; bus.divisor = 32'd7; bus.divsigned = 1'b0; bus.divstart = 1'b1;
        tick();
        bus.divstart = 1'b0;
        repeat (10) tick();
        bus.annul = 1'b1;
        tick();
        bus.annul = 1'b0;
        chk("annul_ready", 32'(bus.div_ready), 32'd1);
        chk("annul_done", 32'(bus.div_done), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.div_done) done_cnt++;
            tick();
        end
        chk("annul_no_done", 32'(done_cnt), 32'd0);

        // annul in idle drops the start
        bus.annul = 1'b1; bus.divstart = 1'b1;
        tick();
        bus.annul = 1'b0; bus.divstart = 1'b0;
        chk("annul_idle_ready", 32'(bus.div_ready), 32'd1);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.div_done || !bus.div_ready) done_cnt++;
            tick();
        end
        chk("annul_idle_nostart", 32'(done_cnt), 32'd0);

        // reset at step 20
        bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.divstart = 1'b1;
        tick();
        bus.divstart = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_ready", 32'(bus.div_ready), 32'd1);
        chk("midrst_done", 32'(bus.div_done), 32'd0);
        chk("midrst_q", bus.quotient, 32'd0);
        chk("midrst_r", bus.remainder, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.div_done) done_cnt++;
            tick();
        end
        chk("midrst_no_done", 32'(done_cnt), 32'd0);

        // start held high: one result per 34 cycles
        bus.dividend = 32'd20; bus.divisor = 32'd3; bus.divsigned = 1'b0; bus.divstart = 1'b1;
        done_cnt   = 0;
        first_done = -1;
        last_done  = -1;
        for (int i = 0; i <= 101; i++) begin
            tick();
            if (bus.div_done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
                last_done = i;
                chk("held_q", bus.quotient, 32'd6);
                chk("held_r", bus.remainder, 32'd2);
            end
        end
        bus.divstart = 1'b0;
        chk("held_count", 32'(done_cnt), 32'd3);
        chk("held_first", 32'(first_done), 32'd32);
        chk("held_span", 32'(last_done - first_done), 32'd68);
        tick();
        chk("held_idle", 32'(bus.div_ready), 32'd1);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rs = 1'($urandom_range(0, 1));
            if (n % 7 == 0) ra = ra >> $urandom_range(0, 31);
            if (n % 11 == 0 && rs) rb = -rb;
            ref_div(ra, rb, rs, rq, rr);
            do_div("rnd", ra, rb, rs, (rb == 32'd0) ? 0 : 32, rq, rr);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
